// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue front end.
package div_pkg;

  localparam int OP_W = 7;
  localparam logic [OP_W-1:0] DIV0_Q = 7'h7F;

  // Operand half of a queued operation; the tag is appended by the user module.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

  function automatic logic is_div0(input op_pair_t op);
    return op.b == '0;
  endfunction

endpackage

// File: rtl/ChuFa_tiny.sv
// 7-bit unsigned combinational divider; a zero dividend yields 0/0.
module ChuFa_tiny (
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic [6:0] q,
  output logic [6:0] r
);

  always_comb begin
    q = '0;
    r = '0;
    // b==0 has no defined result here; the caller substitutes its own.
    if (a != '0 && b != '0) begin
      q = a / b;
      r = a % b;
    end
  end

endmodule

// File: rtl/op_fifo.sv
// Synchronous FIFO with combinational head read and occupancy count.
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/div_issue_ctrl.sv
// Queues operand pairs, issues the FIFO head to ChuFa_tiny and holds the
// registered result under a valid/ready handshake; counts divide-by-zero.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_q,
  output logic [OP_W-1:0]  out_r,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef struct packed {
    op_pair_t         op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t                 wr_entry;
  entry_t                 head;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   push;
  logic                   issue;
  logic                   head_zero;
  logic [OP_W-1:0]        div_q;
  logic [OP_W-1:0]        div_r;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = !full;
  assign push      = in_valid & in_ready;
  assign issue     = !empty & (!out_valid | out_ready);
  assign wr_entry  = '{op: '{a: in_a, b: in_b}, tag: in_tag};
  assign head_zero = is_div0(head.op);

  op_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_entry),
    .pop   (issue),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  ChuFa_tiny u_div (
    .a (head.op.a),
    .b (head.op.b),
    .q (div_q),
    .r (div_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_q     <= head_zero ? DIV0_Q : div_q;
      out_r     <= head_zero ? head.op.a : div_r;
      out_err   <= head_zero;
      out_tag   <= head.tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over the old count but still records a coincident error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= {{(CNT_W-1){1'b0}}, issue & head_zero};
    end else if (issue && head_zero && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign busy = (count != '0) | out_valid;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a queue-based reference model.
module tb_div_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_a;
  logic [6:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_q;
  logic [6:0]       out_r;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [6:0]       q;
    logic [6:0]       r;
    logic             err;
    logic [TAG_W-1:0] tag;
  } res_t;

  div_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_err   (out_err),
    .out_tag   (out_tag),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_div(input int a, input int b, input int tag);
    res_t r;
    r.tag = TAG_W'(tag);
    if (b == 0) begin
      r.q = 7'h7F; r.r = 7'(a); r.err = 1'b1;
    end else begin
      r.q = 7'(a / b); r.r = 7'(a % b); r.err = 1'b0;
    end
    return r;
  endfunction

  function automatic res_t observed();
    return '{q: out_q, r: out_r, err: out_err, tag: out_tag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int a, input int b, input int tag);
    in_valid = 1'b1;
    in_a = 7'(a); in_b = 7'(b); in_tag = TAG_W'(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if ({out_valid, out_q, out_r, out_err, out_tag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b q=%h r=%h e=%b t=%h want all zero", out_valid, out_q, out_r, out_err, out_tag);
    end
    checks++;
    if (err_cnt !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: got cnt=%0d busy=%b rdy=%b want 0 0 1", err_cnt, busy, in_ready);
    end
  endtask

  task automatic test_single();
    res_t exp = ref_div(100, 7, 3);
    out_ready = 1'b1;
    drive_op(100, 7, 3);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: got out_valid=%b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || observed() !== exp) begin
      errors++;
      $display("FAIL single_result: got v=%b %h want v=1 %h", out_valid, observed(), exp);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain: got v=%b busy=%b want 0 0", out_valid, busy);
    end
    $display("single: q=%0d r=%0d tag=%0d", out_q, out_r, out_tag);
  endtask

  task automatic test_zero();
    int ta[3] = '{0, 9, 0};
    int tb[3] = '{5, 0, 0};
    int tc[3] = '{0, 1, 2};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_t exp = ref_div(ta[i], tb[i], i + 4);
      drive_op(ta[i], tb[i], i + 4);
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || observed() !== exp) begin
        errors++;
        $display("FAIL zero_result%0d: got v=%b %h want v=1 %h", i, out_valid, observed(), exp);
      end
      checks++;
      if (err_cnt !== CNT_W'(tc[i])) begin
        errors++; $display("FAIL zero_cnt%0d: got %0d want %0d", i, err_cnt, tc[i]);
      end
      $display("zero %0d/%0d: q=%h r=%h err=%b cnt=%0d", ta[i], tb[i], out_q, out_r, out_err, err_cnt);
      tick();
    end
  endtask

  task automatic test_backpressure();
    int ta[5] = '{127, 64, 50, 13, 1};
    int tb[5] = '{1, 8, 3, 13, 2};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_op(ta[i], tb[i], i + 8);
      tick();
    end
    drive_op(99, 9, 15);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_q !== 7'd127) begin
        errors++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b q=%0d want 0 1 127", c, in_ready, out_valid, out_q);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      res_t exp = ref_div(ta[i], tb[i], i + 8);
      checks++;
      if (out_valid !== 1'b1 || observed() !== exp) begin
        errors++;
        $display("FAIL bp_order%0d: got v=%b %h want v=1 %h", i, out_valid, observed(), exp);
      end
      $display("bp result %0d: q=%0d r=%0d tag=%0d", i, out_q, out_r, out_tag);
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_sixth_blocked: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_streaming();
    int sa[21];
    int sb[21];
    out_ready = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      if (e <= 20) begin
        sa[e] = int'($urandom_range(0, 127));
        sb[e] = int'($urandom_range(0, 127));
        drive_op(sa[e], sb[e], e % 16);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready%0d: got %b want 1", e, in_ready);
      end
      if (e >= 2) begin
        res_t exp = ref_div(sa[e-1], sb[e-1], (e - 1) % 16);
        checks++;
        if (out_valid !== 1'b1 || observed() !== exp) begin
          errors++;
          $display("FAIL stream_result%0d: got v=%b %h want v=1 %h", e - 1, out_valid, observed(), exp);
        end
        $display("stream %0d/%0d: q=%h r=%h err=%b", sa[e-1], sb[e-1], out_q, out_r, out_err);
      end
    end
    tick();
  endtask

  task automatic test_err_clr();
    out_ready = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== '0) begin
      errors++; $display("FAIL clr_idle: got %0d want 0", err_cnt);
    end
    drive_op(5, 0, 1);
    tick();
    in_valid = 1'b0;
    err_clr = 1'b1;
    tick();
    checks++;
    if (err_cnt !== CNT_W'(1) || out_err !== 1'b1) begin
      errors++; $display("FAIL clr_collide: got cnt=%0d err=%b want 1 1", err_cnt, out_err);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== '0) begin
      errors++; $display("FAIL clr_alone: got %0d want 0", err_cnt);
    end
    $display("err_clr: cnt=%0d", err_cnt);
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_op(i, 0, i);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    checks++;
    if (err_cnt !== CNT_W'(CNT_MAX)) begin
      errors++; $display("FAIL saturate: got %0d want %0d", err_cnt, CNT_MAX);
    end
    $display("saturate: cnt=%0d", err_cnt);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_op(i + 20, 0, i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || err_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL mid_before: got v=%b cnt=%0d want 1 1", out_valid, err_cnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== '0 || in_ready !== 1'b1 || out_q !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b busy=%b cnt=%0d rdy=%b q=%h want 0 0 0 1 0", out_valid, busy, err_cnt, in_ready, out_q);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_stale%0d: got v=%b busy=%b want 0 0", c, out_valid, busy);
      end
    end
    $display("reset_mid: v=%b busy=%b", out_valid, busy);
  endtask

  task automatic test_random();
    res_t q[$];
    int zeros = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      checks++;
      if (busy !== (q.size() != 0)) begin
        errors++; $display("FAIL rand_busy%0d: got %b want %b", cyc, busy, q.size() != 0);
      end
      if (q.size() < DEPTH) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL rand_ready%0d: got 0 want 1 (outstanding %0d)", cyc, q.size());
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious%0d: got %h want no result", cyc, observed());
        end else if (observed() !== q[0]) begin
          errors++; $display("FAIL rand_result%0d: got %h want %h", cyc, observed(), q[0]);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_a   = 7'($urandom_range(0, 127));
      in_b   = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      in_tag = TAG_W'($urandom);
      if (out_valid === 1'b1 && out_ready && q.size() != 0) begin
        $display("rand pop: q=%h r=%h err=%b tag=%h", out_q, out_r, out_err, out_tag);
        void'(q.pop_front());
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(ref_div(int'(in_a), int'(in_b), int'(in_tag)));
        if (in_b == 0) zeros++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (observed() !== q[0]) begin
          errors++; $display("FAIL rand_drain: got %h want %h", observed(), q[0]);
        end
        void'(q.pop_front());
      end
      tick();
    end
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rand_idle: got pending=%0d busy=%b want 0 0", q.size(), busy);
    end
    checks++;
    if (err_cnt !== CNT_W'((zeros > CNT_MAX) ? CNT_MAX : zeros)) begin
      errors++; $display("FAIL rand_errcnt: got %0d want %0d", err_cnt, (zeros > CNT_MAX) ? CNT_MAX : zeros);
    end
    $display("random: zeros=%0d cnt=%0d", zeros, err_cnt);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    test_reset();
    test_single();
    test_zero();
    test_backpressure();
    test_streaming();
    test_err_clr();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
